// File: rtl/pwls_i2s_serializer_pkg.sv
// Shared definitions for the I2S serializer: default slot geometry and the
// offset-binary to left-justified two's-complement sample conversion.
package pwls_i2s_serializer_pkg;

  localparam int SLOT_BITS_DEF = 16;
  localparam int BCLK_DIV_DEF  = 2;
  localparam int CONV_W        = 32;

  // Flip the MSB so offset-binary becomes two's complement, then push the
  // sample up against the slot MSB; the shift leaves the LSBs zero-filled.
  // Slots wider than CONV_W are not supported.
  function automatic logic [CONV_W-1:0] to_slot(input logic [CONV_W-1:0] raw,
                                                input int bits,
                                                input int slot_bits);
    logic [CONV_W-1:0] v;
    v = raw;
    v[bits-1] = ~v[bits-1];
    return v << (slot_bits - bits);
  endfunction

endpackage

// File: rtl/pwls_i2s_serializer_timing.sv
// I2S timing generator: divides clk down to bclk, counts bit positions and
// derives the word-select with its one-bit lead ahead of each slot MSB.
module pwls_i2s_timing
  import pwls_i2s_serializer_pkg::*;
#(
  parameter int SLOT_BITS = SLOT_BITS_DEF,
  parameter int BCLK_DIV  = BCLK_DIV_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic bclk,
  output logic lrck,
  output logic fall_evt,
  output logic frame_start,
  output logic slot_start
);

  localparam int DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam int BIT_W = $clog2(2 * SLOT_BITS);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(2 * SLOT_BITS - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic             bclk_q, bclk_d;
  logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic             lrck_q, lrck_d;
  logic [BIT_W-1:0] bit_next;
  logic             div_wrap;

  assign div_wrap    = en && (div_q == DIV_W'(BCLK_DIV - 1));
  assign fall_evt    = div_wrap && bclk_q;
  assign bit_next    = (bit_cnt_q == BIT_LAST) ? '0 : bit_cnt_q + 1'b1;
  assign frame_start = (bit_next == '0);
  assign slot_start  = frame_start || (bit_next == BIT_W'(SLOT_BITS));

  always_comb begin
    div_d     = div_q;
    bclk_d    = bclk_q;
    bit_cnt_d = bit_cnt_q;
    lrck_d    = lrck_q;
    if (!en) begin
      div_d     = '0;
      bclk_d    = 1'b0;
      bit_cnt_d = BIT_LAST;
      lrck_d    = 1'b0;
    end else if (div_wrap) begin
      div_d  = '0;
      bclk_d = ~bclk_q;
      if (bclk_q) begin
        bit_cnt_d = bit_next;
        // Right channel spans the last bit of the left slot up to the
        // second-to-last bit of the right slot.
        lrck_d = (bit_next >= BIT_W'(SLOT_BITS - 1)) &&
                 (bit_next <= BIT_W'(2 * SLOT_BITS - 2));
      end
    end else begin
      div_d = div_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q     <= '0;
      bclk_q    <= 1'b0;
      bit_cnt_q <= BIT_LAST;
      lrck_q    <= 1'b0;
    end else begin
      div_q     <= div_d;
      bclk_q    <= bclk_d;
      bit_cnt_q <= bit_cnt_d;
      lrck_q    <= lrck_d;
    end
  end

  assign bclk = bclk_q;
  assign lrck = lrck_q;

endmodule

// File: rtl/pwls_i2s_serializer.sv
// Mix-sample to I2S serializer: one-entry holding register, per-frame sample
// latch (repeated on underrun) and an MSB-first shift register per slot.
module pwls_i2s_serializer
  import pwls_i2s_serializer_pkg::*;
#(
  parameter int BITS      = 12,
  parameter int SLOT_BITS = SLOT_BITS_DEF,
  parameter int BCLK_DIV  = BCLK_DIV_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            en,
  input  logic [BITS-1:0] in_sample,
  input  logic            in_valid,
  output logic            in_ready,
  output logic            bclk,
  output logic            lrck,
  output logic            sdata,
  output logic            underrun,
  input  logic            underrun_clr
);

  logic                 fall_evt;
  logic                 frame_start;
  logic                 slot_start;
  logic                 load;
  logic                 accept;
  logic                 underrun_set;
  logic [SLOT_BITS-1:0] conv_slot;

  logic [BITS-1:0]      hold_data_q, hold_data_d;
  logic                 hold_full_q, hold_full_d;
  logic [SLOT_BITS-1:0] frame_sample_q, frame_sample_d;
  logic [SLOT_BITS-1:0] shift_q, shift_d;
  logic                 underrun_q, underrun_d;

  pwls_i2s_timing #(
    .SLOT_BITS (SLOT_BITS),
    .BCLK_DIV  (BCLK_DIV)
  ) u_timing (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .bclk        (bclk),
    .lrck        (lrck),
    .fall_evt    (fall_evt),
    .frame_start (frame_start),
    .slot_start  (slot_start)
  );

  assign conv_slot    = SLOT_BITS'(to_slot(CONV_W'(hold_data_q), BITS, SLOT_BITS));
  assign accept       = in_valid && !hold_full_q;
  assign load         = fall_evt && frame_start;
  assign underrun_set = load && !hold_full_q;

  always_comb begin
    hold_data_d    = hold_data_q;
    hold_full_d    = hold_full_q;
    frame_sample_d = frame_sample_q;
    shift_d        = shift_q;
    underrun_d     = underrun_q;

    if (accept) hold_data_d = in_sample;

    // A sample arriving on an empty-register frame start waits a full frame.
    if (hold_full_q) hold_full_d = !load;
    else             hold_full_d = accept;

    if (load && hold_full_q) frame_sample_d = conv_slot;

    if (!en) begin
      shift_d = '0;
    end else if (fall_evt) begin
      if (slot_start) shift_d = frame_sample_d;
      else            shift_d = {shift_q[SLOT_BITS-2:0], 1'b0};
    end

    underrun_d = underrun_set || (underrun_q && !underrun_clr);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_full_q    <= 1'b0;
      frame_sample_q <= '0;
      shift_q        <= '0;
      underrun_q     <= 1'b0;
    end else begin
      hold_full_q    <= hold_full_d;
      frame_sample_q <= frame_sample_d;
      shift_q        <= shift_d;
      underrun_q     <= underrun_d;
    end
  end

  always_ff @(posedge clk) begin
    hold_data_q <= hold_data_d;
  end

  assign in_ready = !hold_full_q;
  assign sdata    = shift_q[SLOT_BITS-1];
  assign underrun = underrun_q;

endmodule

// File: tb/tb_pwls_i2s_serializer.sv
// Directed bench for the I2S serializer: table of samples with expected slot
// words, plus hand-timed sequences for underrun, no-bypass, flow and reset.
module tb_pwls_i2s_serializer;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic [11:0] in_sample;
  logic        in_valid;
  logic        in_ready;
  logic        bclk;
  logic        lrck;
  logic        sdata;
  logic        underrun;
  logic        underrun_clr;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [11:0] sample;
    logic [15:0] slot;
  } vec_t;

  localparam int NV = 6;
  vec_t vecs[NV];

  logic [15:0] got_l, got_r;
  bit          lr_ok, stable_ok, tmo;
  int          highs[$];
  int          exp_highs[5];

  pwls_i2s_serializer #(
    .BITS      (12),
    .SLOT_BITS (16),
    .BCLK_DIV  (2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .en           (en),
    .in_sample    (in_sample),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .bclk         (bclk),
    .lrck         (lrck),
    .sdata        (sdata),
    .underrun     (underrun),
    .underrun_clr (underrun_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at a negedge; offers one sample as soon as in_ready is seen high.
  task automatic push(input logic [11:0] s);
    int g = 0;
    while (!in_ready && g < 300) begin
      @(negedge clk);
      g++;
    end
    if (!in_ready) begin
      check("push_timeout", 32'(in_ready), 32'd1);
    end else begin
      in_sample = s;
      in_valid  = 1'b1;
      @(negedge clk);
      in_valid  = 1'b0;
    end
  endtask

  // Collects the next 32 bclk rising edges as one frame (left then right).
  task automatic read_frame(output logic [15:0] l, output logic [15:0] r,
                            output bit lr_good, output bit st_good, output bit timed_out);
    int   rises = 0;
    int   guard = 0;
    logic pb, ps, exp_lr;
    l = '0;
    r = '0;
    lr_good = 1'b1;
    st_good = 1'b1;
    pb = bclk;
    ps = sdata;
    while (rises < 32 && guard < 400) begin
      @(negedge clk);
      guard++;
      if (bclk && !pb) begin
        if (sdata !== ps) st_good = 1'b0;
        exp_lr = (rises >= 15) && (rises <= 30);
        if (lrck !== exp_lr) lr_good = 1'b0;
        if (rises < 16) l = {l[14:0], sdata};
        else            r = {r[14:0], sdata};
        rises++;
      end
      pb = bclk;
      ps = sdata;
    end
    timed_out = (rises < 32);
  endtask

  task automatic check_frame(input string tag, input logic [15:0] exp_slot);
    check({tag, "_timeout"}, 32'(tmo), 32'd0);
    check({tag, "_left"}, 32'(got_l), 32'(exp_slot));
    check({tag, "_right"}, 32'(got_r), 32'(exp_slot));
    check({tag, "_lrck"}, 32'(lr_ok), 32'd1);
    check({tag, "_stable"}, 32'(stable_ok), 32'd1);
  endtask

  initial begin
    vecs[0] = '{12'hFFF, 16'h7FF0};
    vecs[1] = '{12'h000, 16'h8000};
    vecs[2] = '{12'h800, 16'h0000};
    vecs[3] = '{12'h001, 16'h8010};
    vecs[4] = '{12'h7FF, 16'hFFF0};
    vecs[5] = '{12'hABC, 16'h2BC0};
    exp_highs = '{0, 2, 130, 258, 386};

    reset = 1'b1;
    en = 1'b0;
    in_valid = 1'b0;
    in_sample = '0;
    underrun_clr = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_bclk", 32'(bclk), 32'd0);
    check("rst_lrck", 32'(lrck), 32'd0);
    check("rst_sdata", 32'(sdata), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_underrun", 32'(underrun), 32'd0);

    // Holding register fills while disabled; timing stays parked.
    push(vecs[0].sample);
    check("idle_in_ready", 32'(in_ready), 32'd0);
    repeat (5) @(negedge clk);
    check("idle_bclk", 32'(bclk), 32'd0);

    en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("start_bclk_hi", 32'(bclk), 32'd1);
    @(negedge clk);
    check("start_not_loaded", 32'(in_ready), 32'd0);
    @(negedge clk);
    check("start_loaded", 32'(in_ready), 32'd1);
    check("start_bclk_lo", 32'(bclk), 32'd0);

    for (int i = 0; i < NV; i++) begin
      fork
        read_frame(got_l, got_r, lr_ok, stable_ok, tmo);
        if (i + 1 < NV) push(vecs[i + 1].sample);
      join
      check_frame($sformatf("vec%0d", i), vecs[i].slot);
      check($sformatf("vec%0d_underrun", i), 32'(underrun), 32'd0);
    end

    // Starved frame repeats the last sample and flags underrun.
    read_frame(got_l, got_r, lr_ok, stable_ok, tmo);
    check_frame("starve", 16'h2BC0);
    check("starve_underrun", 32'(underrun), 32'd1);
    underrun_clr = 1'b1;
    @(negedge clk);
    underrun_clr = 1'b0;
    check("clr_underrun", 32'(underrun), 32'd0);

    read_frame(got_l, got_r, lr_ok, stable_ok, tmo);
    check_frame("starve2", 16'h2BC0);
    check("starve2_underrun", 32'(underrun), 32'd1);

    // Clear and a fresh sample both land on the starved frame-start edge.
    @(negedge clk);
    underrun_clr = 1'b1;
    in_sample = 12'h123;
    in_valid = 1'b1;
    @(negedge clk);
    underrun_clr = 1'b0;
    in_valid = 1'b0;
    check("setwins_underrun", 32'(underrun), 32'd1);
    check("nobypass_held", 32'(in_ready), 32'd0);
    read_frame(got_l, got_r, lr_ok, stable_ok, tmo);
    check_frame("nobypass_old", 16'h2BC0);
    read_frame(got_l, got_r, lr_ok, stable_ok, tmo);
    check_frame("nobypass_new", 16'h9230);

    // Continuous in_valid: one acceptance per frame.
    in_sample = 12'h555;
    in_valid = 1'b1;
    for (int i = 0; i < 466; i++) begin
      if (i > 0) @(negedge clk);
      if (in_ready) highs.push_back(i);
    end
    in_valid = 1'b0;
    check("flow_count", 32'(highs.size()), 32'd5);
    for (int k = 0; k < 5 && k < highs.size(); k++)
      check($sformatf("flow_ready_at%0d", k), 32'(highs[k]), 32'(exp_highs[k]));

    // Mid-frame reset at bit 20 of the right slot.
    @(negedge clk);
    check("prerst_lrck", 32'(lrck), 32'd1);
    check("prerst_in_ready", 32'(in_ready), 32'd0);
    check("prerst_underrun", 32'(underrun), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_bclk", 32'(bclk), 32'd0);
    check("midrst_lrck", 32'(lrck), 32'd0);
    check("midrst_sdata", 32'(sdata), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_underrun", 32'(underrun), 32'd0);
    reset = 1'b0;
    en = 1'b0;
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
